hamming_best_match: RTL and testbench

//  Consumes the stream of 16-bit Hamming distances from the 256-bit popcount stage. There is one

---
 rtl/hamming_best_match.sv | 122 ++++++++++++
 tb/tb_hamming_best_match.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_best_match.sv
// hamming_best_match - tracks best/second-best Hamming distance per query and
// emits one thresholded, ratio-tested match result.
module hamming_best_match #(
  parameter int         IDX_W     = 10,
  parameter int         MAX_DIST  = 64,
  parameter logic [3:0] RATIO_NUM = 4'd3,
  parameter logic [3:0] RATIO_DEN = 4'd4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_ready,
  input  logic [15:0]      i_value,
  input  logic             i_last,
  output logic             o_ready,
  output logic             o_match,
  output logic [IDX_W-1:0] o_index,
  output logic [15:0]      o_best,
  output logic [15:0]      o_second,
  output logic             o_ovf
);

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE, DONE} state_t;

  localparam logic [15:0]      MAX_D   = 16'(MAX_DIST);
  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [15:0]      best, best_nxt, second, second_nxt;
  logic [IDX_W-1:0] best_idx, best_idx_nxt, count, count_nxt;
  logic [19:0]      pa, pb;
  logic             ovf_nxt;
  logic             fresh;
  logic             sample;

  // A start pulse clears the tracker first, so a same-cycle sample lands as index 0.
  always_comb begin
    state_nxt    = state;
    best_nxt     = best;
    second_nxt   = second;
    best_idx_nxt = best_idx;
    count_nxt    = count;
    ovf_nxt      = o_ovf;
    sample       = i_ready && (i_start || (state == SCAN));

    if (i_start) begin
      best_nxt     = '1;
      second_nxt   = '1;
      best_idx_nxt = '0;
      count_nxt    = '0;
      ovf_nxt      = 1'b0;
      state_nxt    = SCAN;
    end else if (state == DECIDE) begin
      state_nxt = DONE;
    end

    if (sample) begin
      if (i_value < best_nxt) begin
        second_nxt   = best_nxt;
        best_nxt     = i_value;
        best_idx_nxt = count_nxt;
      end else if (i_value < second_nxt) begin
        second_nxt = i_value;
      end

      if (i_last) begin
        state_nxt = DECIDE;
      end else if (count_nxt == CNT_MAX) begin
        state_nxt = DECIDE;
        ovf_nxt   = 1'b1;
      end

      if (count_nxt != CNT_MAX) begin
        count_nxt = count_nxt + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      best     <= '1;
      second   <= '1;
      best_idx <= '0;
      count    <= '0;
      pa       <= '0;
      pb       <= '0;
      fresh    <= 1'b0;
      o_ready  <= 1'b0;
      o_match  <= 1'b0;
      o_index  <= '0;
      o_best   <= '1;
      o_second <= '1;
      o_ovf    <= 1'b0;
    end else begin
      state    <= state_nxt;
      best     <= best_nxt;
      second   <= second_nxt;
      best_idx <= best_idx_nxt;
      count    <= count_nxt;
      o_ovf    <= ovf_nxt;
      o_ready  <= 1'b0;

      // A start arriving during DECIDE drops the pending result.
      if (state == DECIDE) begin
        pa    <= {4'd0, best} * {16'd0, RATIO_DEN};
        pb    <= {4'd0, second} * {16'd0, RATIO_NUM};
        fresh <= !i_start;
      end

      if ((state == DONE) && fresh) begin
        fresh    <= 1'b0;
        o_ready  <= 1'b1;
        o_match  <= (best <= MAX_D) && (pa < pb);
        o_index  <= best_idx;
        o_best   <= best;
        o_second <= second;
      end
    end
  end

endmodule

// File: tb/tb_hamming_best_match.sv
// tb/tb_hamming_best_match.sv - self-checking bench for hamming_best_match
// using a wide-index and a 4-candidate instance side by side.
module tb_hamming_best_match;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        rdy = 1'b0;
  logic        last = 1'b0;
  logic [15:0] value = 16'd0;

  logic        b_ready, b_match, b_ovf;
  logic [9:0]  b_index;
  logic [15:0] b_best, b_second;
  logic        s_ready, s_match, s_ovf;
  logic [1:0]  s_index;
  logic [15:0] s_best, s_second;

  hamming_best_match #(.IDX_W(10)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_ready(rdy), .i_value(value), .i_last(last),
    .o_ready(b_ready), .o_match(b_match), .o_index(b_index), .o_best(b_best),
    .o_second(b_second), .o_ovf(b_ovf)
  );

  hamming_best_match #(.IDX_W(2)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_ready(rdy), .i_value(value), .i_last(last),
    .o_ready(s_ready), .o_match(s_match), .o_index(s_index), .o_best(s_best),
    .o_second(s_second), .o_ovf(s_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int vals[16];
  int samp_cyc[16];

  int          b_cq[$], s_cq[$];
  logic [43:0] b_rq[$], s_rq[$];

  always @(negedge clk) begin
    if (b_ready) begin
      b_cq.push_back(cyc);
      b_rq.push_back({b_match, b_ovf, b_index, b_best, b_second});
    end
    if (s_ready) begin
      s_cq.push_back(cyc);
      s_rq.push_back({s_match, s_ovf, 8'd0, s_index, s_best, s_second});
    end
  end

  logic [43:0] er_b, er_s;
  int          ec_b, ec_s, en_b, en_s;

  task automatic clear_q();
    b_cq.delete(); b_rq.delete(); s_cq.delete(); s_rq.delete();
  endtask

  // Caller is always positioned 1 time unit after a rising edge.
  task automatic drive(input int n, input bit use_last, input bit merge, input int gap_max);
    if (!merge) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      if (k == 0 && merge) start = 1'b1;
      rdy   = 1'b1;
      value = 16'(vals[k]);
      last  = use_last && (k == n - 1);
      @(posedge clk); #1;
      samp_cyc[k] = cyc;
      start = 1'b0; rdy = 1'b0; last = 1'b0;
      if (k < n - 1) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    end
  endtask

  // Reference: minimum, earliest index of it, minimum of the rest, result 2 clocks after final accepted sample.
  task automatic model(input int n, input bit use_last, input int lim,
                       output logic [43:0] res, output int ecyc, output int ecnt);
    int  np, b, bi, s;
    bit  ovf, m;
    np  = (n < lim) ? n : lim;
    ovf = (n > lim) || (n == lim && !use_last);
    b = 65535; bi = 0; s = 65535;
    for (int j = 0; j < np; j++) if (vals[j] < b) begin b = vals[j]; bi = j; end
    for (int j = 0; j < np; j++) if (j != bi && vals[j] < s) s = vals[j];
    m    = (b <= 64) && (b * 4 < s * 3);
    res  = {m, ovf, 10'(bi), 16'(b), 16'(s)};
    ecnt = (use_last || n >= lim) ? 1 : 0;
    ecyc = samp_cyc[np - 1] + 2;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({b_ready, b_match, b_ovf, b_index, b_best, b_second} !== {3'b0, 10'd0, 16'hFFFF, 16'hFFFF})
      $display("FAIL reset_big: got %h want %h", {b_ready, b_match, b_ovf, b_index, b_best, b_second},
               {3'b0, 10'd0, 16'hFFFF, 16'hFFFF});
    checks++;
    if ({s_ready, s_match, s_ovf, s_index, s_best, s_second} !== {3'b0, 2'd0, 16'hFFFF, 16'hFFFF})
      $display("FAIL reset_small: got %h want %h", {s_ready, s_match, s_ovf, s_index, s_best, s_second},
               {3'b0, 2'd0, 16'hFFFF, 16'hFFFF});
    errors += ((b_ready | b_match | b_ovf | (|b_index) | ~(&b_best) | ~(&b_second)) ? 1 : 0)
            + ((s_ready | s_match | s_ovf | (|s_index) | ~(&s_best) | ~(&s_second)) ? 1 : 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int n;
    bit merge;
    for (int c = 0; c < 6; c++) begin
      merge = 1'b0;
      case (c)
        0: begin n = 3; vals[0] = 40; vals[1] = 20; vals[2] = 30;  end
        1: begin n = 3; vals[0] = 50; vals[1] = 10; vals[2] = 60;  end
        2: begin n = 1; vals[0] = 64; end
        3: begin n = 1; vals[0] = 65; end
        4: begin n = 3; vals[0] = 12; vals[1] = 12; vals[2] = 200; end
        default: begin n = 2; vals[0] = 9; vals[1] = 3; merge = 1'b1; end
      endcase
      clear_q();
      drive(n, 1'b1, merge, 0);
      repeat (4) begin @(posedge clk); #1; end
      model(n, 1'b1, 1024, er_b, ec_b, en_b);
      model(n, 1'b1, 4, er_s, ec_s, en_s);
      checks++;
      if (b_cq.size() != en_b || s_cq.size() != en_s) begin
        errors++;
        $display("FAIL dir%0d_count: got %0d/%0d want %0d/%0d", c, b_cq.size(), s_cq.size(), en_b, en_s);
      end else begin
        checks++;
        if (b_cq[0] != ec_b || s_cq[0] != ec_s) begin
          errors++;
          $display("FAIL dir%0d_latency: got %0d/%0d want %0d/%0d", c, b_cq[0], s_cq[0], ec_b, ec_s);
        end
        checks++;
        if (b_rq[0] !== er_b || s_rq[0] !== er_s) begin
          errors++;
          $display("FAIL dir%0d_result: got %h/%h want %h/%h", c, b_rq[0], s_rq[0], er_b, er_s);
        end
        checks++;
        if ({b_match, b_ovf, b_index, b_best, b_second} !== er_b) begin
          errors++;
          $display("FAIL dir%0d_hold: got %h want %h", c, {b_match, b_ovf, b_index, b_best, b_second}, er_b);
        end
      end
    end
  endtask

  task automatic test_overflow();
    vals[0] = 30; vals[1] = 20; vals[2] = 10; vals[3] = 40; vals[4] = 1;
    clear_q();
    drive(5, 1'b0, 1'b0, 1);
    repeat (4) begin @(posedge clk); #1; end
    model(5, 1'b0, 4, er_s, ec_s, en_s);
    checks++;
    if (b_cq.size() != 0 || s_cq.size() != 1) begin
      errors++;
      $display("FAIL ovf_count: got %0d/%0d want 0/1", b_cq.size(), s_cq.size());
    end else begin
      checks++;
      if (s_cq[0] != ec_s || s_rq[0] !== er_s) begin
        errors++;
        $display("FAIL ovf_result: got %0d %h want %0d %h", s_cq[0], s_rq[0], ec_s, er_s);
      end
    end
    checks++;
    if (s_ovf !== 1'b1 || s_best !== 16'd10) begin
      errors++;
      $display("FAIL ovf_hold: got ovf=%b best=%0d want ovf=1 best=10", s_ovf, s_best);
    end
  endtask

  task automatic test_reset_mid();
    vals[0] = 2; vals[1] = 9;
    clear_q();
    drive(2, 1'b0, 1'b0, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({b_ready, b_match, b_ovf, b_index, b_best, b_second} !== {3'b0, 10'd0, 16'hFFFF, 16'hFFFF}) begin
      errors++;
      $display("FAIL midreset_outputs: got %h want %h",
               {b_ready, b_match, b_ovf, b_index, b_best, b_second}, {3'b0, 10'd0, 16'hFFFF, 16'hFFFF});
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (b_cq.size() != 0 || s_cq.size() != 0) begin
      errors++;
      $display("FAIL midreset_noready: got %0d/%0d want 0/0", b_cq.size(), s_cq.size());
    end
    vals[0] = 5;
    drive(1, 1'b1, 1'b0, 0);
    repeat (4) begin @(posedge clk); #1; end
    model(1, 1'b1, 1024, er_b, ec_b, en_b);
    checks++;
    if (b_rq.size() != 1 || b_rq[0] !== er_b) begin
      errors++;
      $display("FAIL midreset_after: got n=%0d %h want n=1 %h", b_rq.size(),
               (b_rq.size() > 0) ? b_rq[0] : 44'h0, er_b);
    end
  endtask

  task automatic test_abort();
    vals[0] = 3; vals[1] = 7;
    clear_q();
    drive(2, 1'b1, 1'b0, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    checks++;
    if (b_cq.size() != 0 || s_cq.size() != 0) begin
      errors++;
      $display("FAIL abort_noready: got %0d/%0d want 0/0", b_cq.size(), s_cq.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [43:0] ra;
    int ca, na;
    vals[0] = 40; vals[1] = 20; vals[2] = 30;
    clear_q();
    drive(3, 1'b1, 1'b0, 0);
    model(3, 1'b1, 1024, ra, ca, na);
    @(posedge clk); #1;
    vals[0] = 50; vals[1] = 10; vals[2] = 60;
    drive(3, 1'b1, 1'b0, 0);
    repeat (4) begin @(posedge clk); #1; end
    model(3, 1'b1, 1024, er_b, ec_b, en_b);
    checks++;
    if (b_cq.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 2", b_cq.size());
    end else begin
      checks++;
      if (b_cq[0] != ca || b_rq[0] !== ra) begin
        errors++;
        $display("FAIL b2b_first: got %0d %h want %0d %h", b_cq[0], b_rq[0], ca, ra);
      end
      checks++;
      if (b_cq[1] != ec_b || b_rq[1] !== er_b) begin
        errors++;
        $display("FAIL b2b_second: got %0d %h want %0d %h", b_cq[1], b_rq[1], ec_b, er_b);
      end
    end
  endtask

  task automatic test_random();
    int n;
    bit merge;
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(1, 6);
      merge = 1'($urandom_range(0, 1));
      for (int k = 0; k < n; k++) vals[k] = $urandom_range(0, 150);
      clear_q();
      drive(n, 1'b1, merge, 2);
      repeat (4) begin @(posedge clk); #1; end
      model(n, 1'b1, 1024, er_b, ec_b, en_b);
      model(n, 1'b1, 4, er_s, ec_s, en_s);
      checks++;
      if (b_cq.size() != en_b || s_cq.size() != en_s) begin
        errors++;
        $display("FAIL rnd%0d_count: got %0d/%0d want %0d/%0d", t, b_cq.size(), s_cq.size(), en_b, en_s);
      end else begin
        checks++;
        if (b_cq[0] != ec_b || b_rq[0] !== er_b) begin
          errors++;
          $display("FAIL rnd%0d_big: got %0d %h want %0d %h", t, b_cq[0], b_rq[0], ec_b, er_b);
        end
        checks++;
        if (s_cq[0] != ec_s || s_rq[0] !== er_s) begin
          errors++;
          $display("FAIL rnd%0d_small: got %0d %h want %0d %h", t, s_cq[0], s_rq[0], ec_s, er_s);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_overflow();
    test_reset_mid();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
